result_readout_ctrl: RTL and testbench

//  Reader side of the results SRAM: the systolic write path fills rows of packed 24-bit

---
 rtl/result_readout_ctrl.sv | 146 ++++++++++++++
 tb/tb_result_readout_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/result_readout_ctrl.sv
// Results-SRAM reader: streams num_rows rows from base_addr over valid/ready through a 2-entry skid FIFO.
// Optional RESULT_CHECKSUM_EN adds a per-request XOR checksum of all lanes handed off.
module result_readout_ctrl #(
   parameter int ADDRESSSIZE     = 10,
   parameter int PARTIAL_SUM_BW  = 24,
   parameter int MATRIX_SIZE     = 64,
   parameter int WORDSIZE_Result = PARTIAL_SUM_BW*MATRIX_SIZE
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       start,
   input  logic [ADDRESSSIZE-1:0]     base_addr,
   input  logic [ADDRESSSIZE:0]       num_rows,
   output logic                       busy,
   output logic                       done,
   output logic                       sram_rd_en,
   output logic [ADDRESSSIZE-1:0]     sram_address,
   input  logic [WORDSIZE_Result-1:0] sram_data_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WORDSIZE_Result-1:0] out_data,
   output logic                       out_last
`ifdef RESULT_CHECKSUM_EN
   ,output logic [PARTIAL_SUM_BW-1:0] checksum
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                          state_q, state_d;
   logic                            busy_q, busy_d, done_q, done_d;
   logic                            rd_en_q, rd_en_d, vld_q;
   logic [ADDRESSSIZE-1:0]          addr_q, addr_d;
   logic [ADDRESSSIZE:0]            rem_rd_q, rem_rd_d, rem_out_q, rem_out_d;
   logic [1:0][WORDSIZE_Result-1:0] mem_q;
   logic [1:0]                      cnt_q, cnt_d, occ;
   logic                            wr_ptr_q, rd_ptr_q;
   logic                            hs, push, pop;
   logic [WORDSIZE_Result-1:0]      head;

   // An empty FIFO with a read landing this cycle presents the SRAM word directly,
   // which is what lets the first row appear the cycle after its strobe.
   assign out_valid = (cnt_q != 2'd0) | vld_q;
   assign head      = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : sram_data_out;
   assign out_data  = out_valid ? head : '0;
   assign out_last  = out_valid & (rem_out_q == (ADDRESSSIZE+1)'(1));
   assign hs        = out_valid & out_ready;
   assign pop       = (cnt_q != 2'd0) & hs;
   assign push      = vld_q & ~((cnt_q == 2'd0) & hs);
   assign cnt_d     = cnt_q + 2'(push) - 2'(pop);
   assign occ       = cnt_d + 2'(rd_en_q);

   assign busy         = busy_q;
   assign done         = done_q;
   assign sram_rd_en   = rd_en_q;
   assign sram_address = addr_q;

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
      addr_d    = addr_q;
      rem_rd_d  = rem_rd_q;
      rem_out_d = rem_out_q - (ADDRESSSIZE+1)'(hs);
      case (state_q)
         IDLE: if (start) begin
            busy_d    = 1'b1;
            rem_out_d = num_rows;
            if (num_rows != '0) begin
               state_d  = RUN;
               rd_en_d  = 1'b1;
               addr_d   = base_addr;
               rem_rd_d = num_rows - (ADDRESSSIZE+1)'(1);
            end else begin
               // Empty request still spends one cycle in FLUSH so done keeps the usual spacing.
               state_d  = FLUSH;
            end
         end
         RUN: begin
            if (rem_rd_q == '0) state_d = FLUSH;
            else if (occ < 2'd2) begin
               rd_en_d  = 1'b1;
               addr_d   = addr_q + 1'b1;
               rem_rd_d = rem_rd_q - (ADDRESSSIZE+1)'(1);
            end
         end
         FLUSH: if (rem_out_d == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         vld_q     <= 1'b0;
         addr_q    <= '0;
         rem_rd_q  <= '0;
         rem_out_q <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         mem_q     <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         vld_q     <= rd_en_q;
         addr_q    <= addr_d;
         rem_rd_q  <= rem_rd_d;
         rem_out_q <= rem_out_d;
         cnt_q     <= cnt_d;
         if (push) begin
            mem_q[wr_ptr_q] <= sram_data_out;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

`ifdef RESULT_CHECKSUM_EN
   logic [PARTIAL_SUM_BW-1:0] lane_xor, chk_q;

   always_comb begin
      lane_xor = '0;
      for (int i = 0; i < MATRIX_SIZE; i++)
         lane_xor = lane_xor ^ out_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                         chk_q <= '0;
      else if ((state_q == IDLE) & start) chk_q <= '0;
      else if (hs)                       chk_q <= chk_q ^ lane_xor;
   end

   assign checksum = chk_q;
`endif
endmodule

// File: tb/tb_result_readout_ctrl.sv
// Directed bench for result_readout_ctrl: behavioural results SRAM, ready patterns, wrap, reset abort.
// Checksum vector runs only when RESULT_CHECKSUM_EN is defined.
module tb_result_readout_ctrl;
   localparam int AW = 10;
   localparam int BW = 24;
   localparam int MS = 64;
   localparam int W  = BW*MS;

   logic          clk = 1'b0;
   logic          rstn, start, busy, done, sram_rd_en, out_valid, out_ready, out_last;
   logic [AW-1:0] base_addr, sram_address;
   logic [AW:0]   num_rows;
   logic [W-1:0]  sram_q, out_data;
   logic [W-1:0]  sram_mem [1024];
`ifdef RESULT_CHECKSUM_EN
   logic [BW-1:0] checksum;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   result_readout_ctrl #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(BW), .MATRIX_SIZE(MS), .WORDSIZE_Result(W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .busy(busy), .done(done), .sram_rd_en(sram_rd_en), .sram_address(sram_address),
      .sram_data_out(sram_q), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
`ifdef RESULT_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   // Synchronous-read SRAM: data valid the cycle after the strobe.
   always @(posedge clk) if (sram_rd_en) sram_q <= sram_mem[sram_address];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic run_req(input int base, input int num, input logic [3:0] pat,
                          output int first_v, output int done_cyc, output int n_hs,
                          output int n_rd, output int max_out, output logic busy1);
      int cyc;
      logic stalled, rdy;
      logic [W-1:0] held;
      first_v = -1; done_cyc = -1; n_hs = 0; n_rd = 0; max_out = 0;
      stalled = 1'b0; held = '0; busy1 = 1'b0;
      @(negedge clk);
      start = 1'b1; base_addr = base[AW-1:0]; num_rows = num[AW:0]; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done_cyc < 0 && cyc < 300) begin
         if (cyc == 1) busy1 = busy;
         if (sram_rd_en) begin
            chk("rd_addr", 64'(sram_address), 64'((base + n_rd) % 1024));
            n_rd++;
         end
         if (n_rd - n_hs > max_out) max_out = n_rd - n_hs;
         if (stalled) begin
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_hold", 64'(out_data == held), 64'(1));
         end
         rdy = pat[cyc % 4];
         out_ready = rdy;
         stalled = 1'b0;
         if (out_valid) begin
            if (first_v < 0) first_v = cyc;
            if (rdy) begin
               chk("row", 64'(out_data == sram_mem[10'((base + n_hs) % 1024)]), 64'(1));
               chk("last", 64'(out_last), 64'(n_hs == num - 1));
               n_hs++;
            end else begin
               stalled = 1'b1;
               held = out_data;
            end
         end
         if (done) done_cyc = cyc;
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      if (done_cyc < 0) chk("timeout", 64'(0), 64'(1));
      else begin
         chk("done_width", 64'(done), 64'(0));
         chk("busy_after", 64'(busy), 64'(0));
      end
   endtask

   initial begin
      int fv, dc, nh, nr, mo, dcnt;
      logic b1;
      logic [BW-1:0] v;
      rstn = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b0; sram_q = '0;
      for (int a = 0; a < 1024; a++) begin
         v = BW'(a + 1);
         sram_mem[a] = {MS{v}};
      end
      sram_mem[100] = W'(24'h00000F);
      sram_mem[101] = W'(24'h0000F0);

      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rden", 64'(sram_rd_en), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_addr", 64'(sram_address), 64'(0));
      chk("rst_data", 64'(out_data == '0), 64'(1));
      rstn = 1'b1;

      // 1: four rows, ready always high
      run_req(0, 4, 4'b1111, fv, dc, nh, nr, mo, b1);
      chk("t1_first_valid", 64'(fv), 64'(2));
      chk("t1_done_cyc", 64'(dc), 64'(6));
      chk("t1_hs", 64'(nh), 64'(4));
      chk("t1_reads", 64'(nr), 64'(4));
      chk("t1_busy", 64'(b1), 64'(1));
      chk("t1_lane0_row1", 64'(sram_mem[0][BW-1:0]), 64'(1));

      // 2: ready toggles, stalls hold data
      run_req(0, 4, 4'b1001, fv, dc, nh, nr, mo, b1);
      chk("t2_hs", 64'(nh), 64'(4));
      chk("t2_reads", 64'(nr), 64'(4));
      chk("t2_outstanding", 64'(mo <= 2), 64'(1));

      // 3: zero rows
      run_req(0, 0, 4'b1111, fv, dc, nh, nr, mo, b1);
      chk("t3_reads", 64'(nr), 64'(0));
      chk("t3_no_valid", 64'(fv < 0), 64'(1));
      chk("t3_done_cyc", 64'(dc), 64'(2));
      chk("t3_busy", 64'(b1), 64'(1));

      // 4: address wrap 1022,1023,0
      run_req(1022, 3, 4'b1111, fv, dc, nh, nr, mo, b1);
      chk("t4_hs", 64'(nh), 64'(3));
      chk("t4_reads", 64'(nr), 64'(3));

      // 5: reset after two of eight rows
      @(negedge clk);
      start = 1'b1; base_addr = '0; num_rows = 11'd8; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("t5_busy", 64'(busy), 64'(0));
      chk("t5_rden", 64'(sram_rd_en), 64'(0));
      chk("t5_valid", 64'(out_valid), 64'(0));
      chk("t5_last", 64'(out_last), 64'(0));
      chk("t5_addr", 64'(sram_address), 64'(0));
      chk("t5_data", 64'(out_data == '0), 64'(1));
      dcnt = 0;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      rstn = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("t5_no_done", 64'(dcnt), 64'(0));
      run_req(5, 1, 4'b1111, fv, dc, nh, nr, mo, b1);
      chk("t5_hs", 64'(nh), 64'(1));
      chk("t5_first_valid", 64'(fv), 64'(2));
      chk("t5_done_cyc", 64'(dc), 64'(3));

`ifdef RESULT_CHECKSUM_EN
      // 6: lane0 0x00000F then 0x0000F0
      run_req(100, 2, 4'b1111, fv, dc, nh, nr, mo, b1);
      chk("t6_hs", 64'(nh), 64'(2));
      chk("t6_checksum", 64'(checksum), 64'(24'h0000FF));
      @(negedge clk);
      chk("t6_checksum_hold", 64'(checksum), 64'(24'h0000FF));
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
